// File: rtl/sensor_pulse_pkg.sv
// Shared types and constants for the sensor pulse generator.
// Optional pulse counters are enabled by defining SENSOR_PULSE_COUNT_EN.
package sensor_pulse_pkg;

  typedef enum logic {
    ST_HIGH = 1'b0,
    ST_LOW  = 1'b1
  } pulse_state_e;

  localparam int unsigned DEFAULT_M       = 196721;
  localparam int unsigned DEFAULT_PULSE_W = 66;
  localparam int unsigned CNT_W           = 16;

  // Accumulator must hold any residue below M plus one full rate step.
  function automatic int unsigned acc_width(input int unsigned m, input int unsigned rate_w);
    return $clog2(m + (32'd1 << rate_w));
  endfunction

endpackage

// File: rtl/sensor_pulse_chan.sv
// One pulse channel: phase accumulator, low-time timer, sticky overrun flag.
// With SENSOR_PULSE_COUNT_EN defined, also a wrapping count of started pulses.
module sensor_pulse_chan
  import sensor_pulse_pkg::*;
#(
  parameter int unsigned RATE_W  = 8,
  parameter int unsigned M       = DEFAULT_M,
  parameter int unsigned PULSE_W = DEFAULT_PULSE_W,
  parameter int unsigned ACC_W   = acc_width(M, RATE_W)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [RATE_W-1:0] rate_i,
  input  logic              ovr_clr_i,
  output logic              npulse_o,
  output logic              overrun_o
`ifdef SENSOR_PULSE_COUNT_EN
  ,output logic [CNT_W-1:0] pulse_cnt_o
`endif
);

  localparam int unsigned TMR_W = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  sum_d;
  logic [RATE_W-1:0] rate_prev_q;
  logic [TMR_W-1:0]  timer_q;
  pulse_state_e      state_q;
  logic              npulse_q;
  logic              overrun_q;
  logic              idle_d;
  logic              resync_d;
  logic              event_d;
`ifdef SENSOR_PULSE_COUNT_EN
  logic [CNT_W-1:0]  cnt_q;
`endif

  always_comb begin
    idle_d   = (rate_i == '0);
    resync_d = (rate_i != rate_prev_q);
    sum_d    = acc_q + ACC_W'(rate_i);
    event_d  = !idle_d && !resync_d && (sum_d >= ACC_W'(M));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q       <= '0;
      rate_prev_q <= '0;
      timer_q     <= '0;
      state_q     <= ST_HIGH;
      npulse_q    <= 1'b1;
      overrun_q   <= 1'b0;
`ifdef SENSOR_PULSE_COUNT_EN
      cnt_q       <= '0;
`endif
    end else begin
      rate_prev_q <= rate_i;
      if (idle_d) begin
        acc_q    <= '0;
        state_q  <= ST_HIGH;
        npulse_q <= 1'b1;
        timer_q  <= '0;
      end else begin
        // A rate change restarts the phase but leaves any pulse in flight alone.
        if (resync_d)     acc_q <= '0;
        else if (event_d) acc_q <= sum_d - ACC_W'(M);
        else              acc_q <= sum_d;

        if (state_q == ST_HIGH) begin
          if (event_d) begin
            state_q  <= ST_LOW;
            npulse_q <= 1'b0;
            timer_q  <= TMR_W'(PULSE_W - 1);
`ifdef SENSOR_PULSE_COUNT_EN
            cnt_q    <= cnt_q + 1'b1;
`endif
          end
        end else begin
          if (timer_q == '0) begin
            state_q  <= ST_HIGH;
            npulse_q <= 1'b1;
          end else begin
            timer_q  <= timer_q - 1'b1;
          end
        end
      end

      // A new overrun outranks a clear in the same cycle.
      if (event_d && (state_q == ST_LOW)) overrun_q <= 1'b1;
      else if (ovr_clr_i)                 overrun_q <= 1'b0;
    end
  end

  assign npulse_o  = npulse_q;
  assign overrun_o = overrun_q;
`ifdef SENSOR_PULSE_COUNT_EN
  assign pulse_cnt_o = cnt_q;
`endif

endmodule

// File: rtl/sensor_pulse_gen.sv
// Multi-channel active-low sensor pulse generator (crank/wheel emulation).
// Define SENSOR_PULSE_COUNT_EN to expose per-channel 16-bit pulse counters.
module sensor_pulse_gen
  import sensor_pulse_pkg::*;
#(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned RATE_W   = 8,
  parameter int unsigned M        = DEFAULT_M,
  parameter int unsigned PULSE_W  = DEFAULT_PULSE_W
) (
  input  logic                       core_CLK,
  input  logic                       core_nReset,
  input  logic [CHANNELS*RATE_W-1:0] rate,
  input  logic [CHANNELS-1:0]        ovr_clr,
  output logic [CHANNELS-1:0]        npulse,
  output logic [CHANNELS-1:0]        overrun
`ifdef SENSOR_PULSE_COUNT_EN
  ,output logic [CHANNELS*CNT_W-1:0] pulse_count
`endif
);

  localparam int unsigned ACC_W = acc_width(M, RATE_W);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    sensor_pulse_chan #(
      .RATE_W  (RATE_W),
      .M       (M),
      .PULSE_W (PULSE_W),
      .ACC_W   (ACC_W)
    ) u_chan (
      .clk_i       (core_CLK),
      .rst_ni      (core_nReset),
      .rate_i      (rate[i*RATE_W +: RATE_W]),
      .ovr_clr_i   (ovr_clr[i]),
      .npulse_o    (npulse[i]),
      .overrun_o   (overrun[i])
`ifdef SENSOR_PULSE_COUNT_EN
      ,.pulse_cnt_o (pulse_count[i*CNT_W +: CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_sensor_pulse_gen.sv
// Directed bench for sensor_pulse_gen with M=100, PULSE_W=4, two channels.
module tb_sensor_pulse_gen;

  logic        clk;
  logic        rst_n;
  logic [15:0] rate;
  logic [1:0]  ovr_clr;
  logic [1:0]  npulse;
  logic [1:0]  overrun;
`ifdef SENSOR_PULSE_COUNT_EN
  logic [31:0] pulse_count;
`endif

  int checks   = 0;
  int failures = 0;
  int n, lo, hi;
`ifdef SENSOR_PULSE_COUNT_EN
  int c0;
`endif

  sensor_pulse_gen #(
    .CHANNELS (2),
    .RATE_W   (8),
    .M        (100),
    .PULSE_W  (4)
  ) dut (
    .core_CLK    (clk),
    .core_nReset (rst_n),
    .rate        (rate),
    .ovr_clr     (ovr_clr),
    .npulse      (npulse),
    .overrun     (overrun)
`ifdef SENSOR_PULSE_COUNT_EN
    ,.pulse_count (pulse_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Ticks until channel ch is sampled low; returns number of ticks taken.
  task automatic wait_fall(input int ch, output int cnt);
    cnt = 0;
    while (cnt < 300) begin
      tick();
      cnt++;
      if (npulse[ch] == 1'b0) break;
    end
  endtask

  // Called on a sample just after a fall; ends on the sample of the next fall.
  task automatic measure(input int ch, output int low_len, output int high_len);
    low_len  = 0;
    high_len = 0;
    while (npulse[ch] == 1'b0 && low_len < 300) begin
      low_len++;
      tick();
    end
    while (npulse[ch] == 1'b1 && high_len < 300) begin
      high_len++;
      tick();
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    rate    = '0;
    ovr_clr = '0;
    tick();
    tick();
    chk("reset_npulse", int'(npulse), 3);
    chk("reset_overrun", int'(overrun), 0);
`ifdef SENSOR_PULSE_COUNT_EN
    chk("reset_count", int'(pulse_count), 0);
`endif
    rst_n = 1'b1;

    // Idle channels stay high
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("idle_npulse", int'(npulse), 3);
      chk("idle_overrun", int'(overrun), 0);
    end

    // ch0 rate 10: resync edge + 10 accumulations, then period 10, low 4
    rate[7:0] = 8'd10;
    wait_fall(0, n);
    chk("r10_first_fall", n, 11);
    chk("r10_ch1_high", int'(npulse[1]), 1);
`ifdef SENSOR_PULSE_COUNT_EN
    chk("r10_count1", int'(pulse_count[15:0]), 1);
`endif
    for (int i = 0; i < 3; i++) begin
      measure(0, lo, hi);
      chk("r10_low", lo, 4);
      chk("r10_high", hi, 6);
    end
    chk("r10_overrun", int'(overrun), 0);
`ifdef SENSOR_PULSE_COUNT_EN
    chk("r10_count4", int'(pulse_count[15:0]), 4);
`endif

    // ch0 rate 3: first event after 34 accumulations, then 33,33,34
    rate[7:0] = 8'd0;
    tick();
    tick();
    tick();
    chk("r0_high", int'(npulse[0]), 1);
    rate[7:0] = 8'd3;
    wait_fall(0, n);
    chk("r3_first_fall", n, 35);
`ifdef SENSOR_PULSE_COUNT_EN
    c0 = int'(pulse_count[15:0]);
`endif
    measure(0, lo, hi);
    chk("r3_low", lo, 4);
    chk("r3_period1", lo + hi, 33);
    measure(0, lo, hi);
    chk("r3_period2", lo + hi, 33);
    measure(0, lo, hi);
    chk("r3_period3", lo + hi, 34);
`ifdef SENSOR_PULSE_COUNT_EN
    chk("r3_count", int'(pulse_count[15:0]) - c0, 3);
`endif
    chk("r3_overrun", int'(overrun), 0);

    // ch1 rate 200: period below PULSE_W, overrun during the first pulse
    rate = 16'h0000;
    tick();
    tick();
    rate[15:8] = 8'd200;
    wait_fall(1, n);
    chk("r200_first_fall", n, 2);
    measure(1, lo, hi);
    chk("r200_low1", lo, 4);
    chk("r200_high1", hi, 1);
    chk("r200_overrun", int'(overrun), 2);
    measure(1, lo, hi);
    chk("r200_low2", lo, 4);
    chk("r200_high2", hi, 1);
    ovr_clr = 2'b10;
    tick();
    ovr_clr = 2'b00;
    chk("r200_clr_loses", int'(overrun[1]), 1);
    rate[15:8] = 8'd0;
    tick();
    chk("r200_stop_high", int'(npulse[1]), 1);
    chk("r200_stop_keep", int'(overrun[1]), 1);
    ovr_clr = 2'b10;
    tick();
    ovr_clr = 2'b00;
    chk("ovr_clr_clears", int'(overrun[1]), 0);

    // ch0 rate to 0 mid-pulse truncates it; back to 10 restarts phase
    rate[7:0] = 8'd10;
    wait_fall(0, n);
    chk("trunc_fall", n, 11);
    tick();
    chk("trunc_still_low", int'(npulse[0]), 0);
    rate[7:0] = 8'd0;
    tick();
    chk("trunc_high", int'(npulse[0]), 1);
    tick();
    tick();
    chk("trunc_stays_high", int'(npulse[0]), 1);
    rate[7:0] = 8'd10;
    wait_fall(0, n);
    chk("trunc_refall", n, 11);
    measure(0, lo, hi);
    chk("trunc_low", lo, 4);
    chk("trunc_period", lo + hi, 10);

    // Asynchronous reset with both channels mid-pulse
    rate = 16'h0000;
    tick();
    tick();
    tick();
    rate = {8'd200, 8'd10};
    for (int i = 0; i < 12; i++) tick();
    chk("pre_rst_npulse", int'(npulse), 0);
    chk("pre_rst_overrun", int'(overrun), 2);
    rst_n = 1'b0;
    #1;
    chk("async_rst_npulse", int'(npulse), 3);
    chk("async_rst_overrun", int'(overrun), 0);
`ifdef SENSOR_PULSE_COUNT_EN
    chk("async_rst_count", int'(pulse_count), 0);
`endif
    tick();
    rate = '0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_npulse", int'(npulse), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
